// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronized sources, per-channel edge/level capture,
// enable masking, lowest-index-first vector and an active-low registered IRQ.
module irq_ctrl #(
    parameter int          N           = 8,
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  MODE_RST    = 8'hFF
) (
    input  logic         CLK,
    input  logic         RES_N,
    input  logic [N-1:0] SRC,
    input  logic         CS,
    input  logic         R_W,
    input  logic [1:0]   ADDR,
    input  logic [7:0]   DB_IN,
    output logic [7:0]   DB_OUT,
    output logic         IRQ_N
);

    // Channels that physically exist; everything above reads 0 and ignores writes.
    localparam logic [7:0] CH_MASK = 8'((16'd1 << N) - 16'd1);

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_ENABLE = 2'd1;
    localparam logic [1:0] ADDR_MODE   = 2'd2;
    localparam logic [1:0] ADDR_VECTOR = 2'd3;

    // Lowest set index wins; result is {valid, 4'b0, idx}.
    function automatic logic [7:0] vector_of(input logic [7:0] req);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                v = {1'b1, 4'b0000, 3'(i)};
            end else begin
                v = v;
            end
        end
        return v;
    endfunction

    logic [7:0] src_ext_s;
    logic [7:0] s_sync_s;
    logic [7:0] rise_s;
    logic [7:0] ack_s;
    logic       wr_s;

    logic [7:0] s_prev_q,  s_prev_d;
    logic [7:0] pending_q, pending_d;
    logic [7:0] enable_q,  enable_d;
    logic [7:0] mode_q,    mode_d;
    logic       irq_n_q,   irq_n_d;

    // Widen the source vector to the fixed 8-bit register width.
    always_comb begin
        src_ext_s = 8'h00;
        for (int i = 0; i < N; i++) begin
            src_ext_s[i] = SRC[i];
        end
    end

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s_sync_s = src_ext_s;
        end else begin : g_sync
            logic [7:0] sync_q [SYNC_STAGES];

            // Metastability chain for the asynchronous sources.
            always_ff @(posedge CLK) begin
                if (!RES_N) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= 8'h00;
                    end
                end else begin
                    sync_q[0] <= src_ext_s;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign s_sync_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign wr_s   = CS & ~R_W;
    assign rise_s = s_sync_s & ~s_prev_q;
    assign ack_s  = (wr_s && (ADDR == ADDR_VECTOR)) ? (DB_IN & CH_MASK) : 8'h00;

    // Next-state for control registers, pending capture and the IRQ line.
    always_comb begin
        s_prev_d = s_sync_s;

        if (wr_s && (ADDR == ADDR_ENABLE)) begin
            enable_d = DB_IN & CH_MASK;
        end else begin
            enable_d = enable_q;
        end

        if (wr_s && (ADDR == ADDR_MODE)) begin
            mode_d = DB_IN & CH_MASK;
        end else begin
            mode_d = mode_q;
        end

        pending_d = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (!mode_q[i] && mode_d[i]) begin
                // Switching level -> edge starts the channel from a clean slate.
                pending_d[i] = 1'b0;
            end else if (!mode_d[i]) begin
                // Level channel (incl. edge -> level switch) mirrors the input.
                pending_d[i] = s_sync_s[i];
            end else begin
                // Edge channel: a new edge beats a simultaneous ACK.
                pending_d[i] = rise_s[i] | (pending_q[i] & ~ack_s[i]);
            end
        end

        irq_n_d = ~|(pending_q & enable_q);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RES_N) begin
            s_prev_q  <= 8'h00;
            pending_q <= 8'h00;
            enable_q  <= 8'h00;
            mode_q    <= MODE_RST & CH_MASK;
            irq_n_q   <= 1'b1;
        end else begin
            s_prev_q  <= s_prev_d;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            irq_n_q   <= irq_n_d;
        end
    end

    // Side-effect-free read mux; idle bus reads as zero.
    always_comb begin
        DB_OUT = 8'h00;
        if (CS && R_W) begin
            case (ADDR)
                ADDR_STATUS: DB_OUT = pending_q;
                ADDR_ENABLE: DB_OUT = enable_q;
                ADDR_MODE:   DB_OUT = mode_q;
                ADDR_VECTOR: DB_OUT = vector_of(pending_q & enable_q);
                default:     DB_OUT = 8'h00;
            endcase
        end else begin
            DB_OUT = 8'h00;
        end
    end

    assign IRQ_N = irq_n_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl (N=8, SYNC_STAGES=2) with hand-computed expectations.
module tb_irq_ctrl;

    logic       CLK;
    logic       RES_N;
    logic [7:0] SRC;
    logic       CS;
    logic       R_W;
    logic [1:0] ADDR;
    logic [7:0] DB_IN;
    logic [7:0] DB_OUT;
    logic       IRQ_N;

    int n_checks;
    int n_pass;

    irq_ctrl #(.N(8), .SYNC_STAGES(2), .MODE_RST(8'hFF)) dut (
        .CLK    (CLK),
        .RES_N  (RES_N),
        .SRC    (SRC),
        .CS     (CS),
        .R_W    (R_W),
        .ADDR   (ADDR),
        .DB_IN  (DB_IN),
        .DB_OUT (DB_OUT),
        .IRQ_N  (IRQ_N)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        CS = 1'b1; R_W = 1'b0; ADDR = a; DB_IN = d;
        step();
        CS = 1'b0; R_W = 1'b1; DB_IN = 8'h00;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        CS = 1'b1; R_W = 1'b1; ADDR = a;
        #1;
        d = DB_OUT;
        CS = 1'b0;
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] v;
        rd(a, v);
        check(tag, v, exp);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        RES_N = 1'b0; SRC = 8'h00; CS = 1'b0; R_W = 1'b1; ADDR = 2'd0; DB_IN = 8'h00;
        step(); step();
        RES_N = 1'b1;

        // Reset state
        check("rst_irq", {7'b0, IRQ_N}, 8'h01);
        chk_reg("rst_status", 2'd0, 8'h00);
        chk_reg("rst_enable", 2'd1, 8'h00);
        chk_reg("rst_mode",   2'd2, 8'hFF);
        CS = 1'b0; R_W = 1'b1; #1;
        check("idle_dbout", DB_OUT, 8'h00);

        // Edge latency on channel 0
        wr(2'd1, 8'h01);
        SRC = 8'h01;
        step();                                   // edge 0
        chk_reg("lat_e0_status", 2'd0, 8'h00);
        step();                                   // edge 1
        chk_reg("lat_e1_status", 2'd0, 8'h00);
        step();                                   // edge 2
        chk_reg("lat_e2_status", 2'd0, 8'h01);
        check("lat_e2_irq", {7'b0, IRQ_N}, 8'h01);
        step();                                   // edge 3
        check("lat_e3_irq", {7'b0, IRQ_N}, 8'h00);
        chk_reg("lat_vector", 2'd3, 8'h80);
        wr(2'd3, 8'h01);
        chk_reg("lat_ack_status", 2'd0, 8'h00);
        step();
        check("lat_ack_irq", {7'b0, IRQ_N}, 8'h01);
        SRC = 8'h00;
        step(); step(); step();

        // Priority between channels 5 and 2
        wr(2'd1, 8'hFF);
        SRC = 8'h24;
        step(); step(); step(); step();
        check("pri_irq", {7'b0, IRQ_N}, 8'h00);
        chk_reg("pri_vec0", 2'd3, 8'h82);
        wr(2'd3, 8'h04);
        chk_reg("pri_vec1", 2'd3, 8'h85);
        wr(2'd3, 8'h20);
        check("pri_irq_hold", {7'b0, IRQ_N}, 8'h00);
        chk_reg("pri_status", 2'd0, 8'h00);
        step();
        check("pri_irq_rel", {7'b0, IRQ_N}, 8'h01);
        SRC = 8'h00;
        step(); step(); step();

        // Set wins over simultaneous ACK on channel 3
        SRC = 8'h08;
        step(); step();
        wr(2'd3, 8'h08);                          // edge 2: rise detected here
        chk_reg("col_status", 2'd0, 8'h08);
        wr(2'd3, 8'h08);
        chk_reg("col_cleared", 2'd0, 8'h00);
        SRC = 8'h00;
        step(); step(); step();

        // Level mode on channel 1
        wr(2'd2, 8'h00);
        chk_reg("lvl_mode", 2'd2, 8'h00);
        SRC = 8'h02;
        step();                                   // edge 0
        step();                                   // edge 1
        chk_reg("lvl_e1_status", 2'd0, 8'h00);
        step();                                   // edge 2
        chk_reg("lvl_e2_status", 2'd0, 8'h02);
        wr(2'd3, 8'h02);                          // edge 3
        chk_reg("lvl_ack_status", 2'd0, 8'h02);
        step();                                   // edge 4
        check("lvl_irq", {7'b0, IRQ_N}, 8'h00);
        SRC = 8'h00;
        step();                                   // edge 5
        step();                                   // edge 6
        chk_reg("lvl_e6_status", 2'd0, 8'h02);
        step();                                   // edge 7
        chk_reg("lvl_e7_status", 2'd0, 8'h00);
        step();
        check("lvl_irq_rel", {7'b0, IRQ_N}, 8'h01);

        // Masking on channel 4
        wr(2'd2, 8'hFF);
        wr(2'd1, 8'h00);
        SRC = 8'h10;
        step(); step(); step(); step();
        chk_reg("msk_status", 2'd0, 8'h10);
        check("msk_irq_off", {7'b0, IRQ_N}, 8'h01);
        chk_reg("msk_vector", 2'd3, 8'h00);
        wr(2'd1, 8'h10);
        check("msk_irq_same", {7'b0, IRQ_N}, 8'h01);
        step();
        check("msk_irq_on", {7'b0, IRQ_N}, 8'h00);

        // Reset mid-operation
        wr(2'd1, 8'hFF);
        SRC = 8'hFF;
        step(); step(); step(); step();
        chk_reg("mid_status", 2'd0, 8'hFF);
        check("mid_irq", {7'b0, IRQ_N}, 8'h00);
        RES_N = 1'b0;
        step();
        RES_N = 1'b1;
        chk_reg("mid_rst_status", 2'd0, 8'h00);
        chk_reg("mid_rst_enable", 2'd1, 8'h00);
        chk_reg("mid_rst_mode",   2'd2, 8'hFF);
        check("mid_rst_irq", {7'b0, IRQ_N}, 8'h01);
        step();                                   // release edge 1
        step();                                   // release edge 2
        chk_reg("rel_e2_status", 2'd0, 8'h00);
        step();                                   // release edge 3
        chk_reg("rel_e3_status", 2'd0, 8'hFF);

        // Mode switches: edge->level reloads, level->edge clears
        wr(2'd2, 8'h00);
        chk_reg("sw_lvl_status", 2'd0, 8'hFF);
        wr(2'd2, 8'h01);
        chk_reg("sw_edge_status", 2'd0, 8'hFE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter N, default 8: number of interrupt channels, legal range 1..8.
REQ-002 Parameter SYNC_STAGES, default 2: input synchronizer depth, legal range 0..3.
REQ-003 Parameter MODE_RST, default 8'hFF: reset value of the MODE register; bit=1 means edge, bit=0 means level.
REQ-004 Port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 Port RES_N, input, 1 bit: reset; synchronous and active-low.
REQ-006 Port SRC, input, N bits: interrupt sources, active-high, asynchronous to CLK.
REQ-007 Port CS, input, 1 bit: register select.
REQ-008 Port R_W, input, 1 bit: 1 = read, 0 = write (MPU bus convention).
REQ-009 Port ADDR, input, 2 bits: register index.
REQ-010 Port DB_IN, input, 8 bits: write data.
REQ-011 Port DB_OUT, output, 8 bits: read data.
REQ-012 Port IRQ_N, output, 1 bit: active-low interrupt request to the MPU.

Function
REQ-013 Register map: 0 = STATUS (R; pending bits). 1 = ENABLE (R/W). 2 = MODE (R/W). 3 = VECTOR on read, ACK on write (write-1-to-clear pending).
REQ-014 Bits at and above N: read as 0; writes to them ignored.
REQ-015 Synchronizer: SRC passes through SYNC_STAGES flops, giving s_sync; with SYNC_STAGES=0, s_sync equals SRC.
REQ-016 Edge detect: s_prev is s_sync delayed by 1 register; a rising edge is s_sync & ~s_prev.
REQ-017 Edge channel: pending bit is set on a rising edge and holds until an ACK write with that bit = 1.
REQ-018 Level channel: pending is registered s_sync each cycle; ACK writes have no effect.
REQ-019 Simultaneous rising edge and ACK on the same channel in the same cycle: pending remains 1 (set wins).
REQ-020 MODE write that changes a channel from level to edge: clears that channel's pending in the same edge.
REQ-021 MODE write from edge to level: pending reloads from s_sync.
REQ-022 ENABLE masks only; pending is unaffected by ENABLE writes.
REQ-023 Writes take effect when CS=1 and R_W=0 at the clock edge; writes to STATUS are ignored.
REQ-024 IRQ_N is a register loaded each cycle with ~|(pending & ENABLE); it goes low 1 cycle after the enabled pending bit sets.
REQ-025 Latency: SRC stable high before edge 0 with SYNC_STAGES=S gives pending=1 after edge S and IRQ_N=0 after edge S+1.
REQ-026 VECTOR read value: {valid, 4'b0, idx[2:0]}.
REQ-027 VECTOR idx is the lowest-index bit of pending & ENABLE (index 0 is highest priority); valid=0 and idx=0 when none is set.
REQ-028 DB_OUT is combinational: the addressed register when CS=1 and R_W=1, otherwise 8'h00.
REQ-029 Reads have no side effects.
REQ-030 Multiple pending bits: IRQ_N stays low until all enabled pending bits clear; after each ACK, VECTOR advances to the next index.

Reset
REQ-031 While RES_N=0 at a clock edge, the following load their reset values:
- synchronizer flops, s_prev, pending: 0
- ENABLE: 8'h00
- MODE: MODE_RST masked to N bits
- IRQ_N: 1
REQ-032 Reset mid-operation discards all pending and in-flight synchronizer state; no interrupt survives reset.
REQ-033 An edge-mode source held high across reset release is detected as one rising edge, because s_prev resets to 0.

Verification
REQ-034 The bench covers, with N=8 and SYNC_STAGES=2:
- Edge latency: ENABLE=8'h01, MODE=8'hFF, SRC[0] rises before edge 0 -> STATUS=8'h01 after edge 2; IRQ_N=0 after edge 3; VECTOR reads 8'h80.
- Priority: SRC[5] and SRC[2] rise together, ENABLE=8'hFF -> VECTOR=8'h82; ACK 8'h04 -> VECTOR=8'h85; ACK 8'h20 -> IRQ_N=1 one cycle later.
- Set-wins collision: ACK 8'h08 written in the cycle SRC[3]'s edge is detected -> STATUS bit 3 stays 1.
- Level mode: MODE=8'h00, SRC[1] high 5 cycles then low -> STATUS bit 1 follows SRC delayed 3 cycles; ACK has no effect; IRQ_N returns to 1 without ACK.
- Masking: STATUS=8'h10, ENABLE=8'h00 -> IRQ_N=1 and VECTOR=8'h00; ENABLE=8'h10 -> IRQ_N=0 next cycle.
- Reset mid-operation: STATUS=8'hFF and IRQ_N=0, RES_N low for 1 edge -> STATUS=8'h00, ENABLE=8'h00, MODE=8'hFF, IRQ_N=1; a source held high across reset sets pending 3 edges after release.
